sram_wb_ctrl: RTL and testbench
===============================

Name: sram_wb_ctrl

Overview:
Wishbone B4 classic slave that turns single-beat bus cycles into timed accesses on one external asynchronous 32-bit SRAM bank. It sits directly downstream of the CPU data-memory Wishbone master and consumes its cyc/stb/we/sel/adr/dat requests. It returns wb_ack_o and read data. Byte-lane extraction and sign extension stay in the master; this block always returns the full word.

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width
SRAM_ADDR_WIDTH, 20, SRAM word-address width
SRAM_DATA_WIDTH, 32, SRAM data width; must equal DATA_WIDTH
WAIT_CYCLES, 1, extra cycles oe_n/we_n are held low beyond the first; range 0..15

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_ack_o  out  1  transfer acknowledge
wb_adr_i  in  ADDR_WIDTH  byte address
wb_dat_i  in  DATA_WIDTH  write data
wb_dat_o  out  DATA_WIDTH  read data
wb_sel_i  in  DATA_WIDTH/8  byte enables
wb_we_i  in  1  1 = write
sram_addr_o  out  SRAM_ADDR_WIDTH  SRAM word address
sram_data_i  in  SRAM_DATA_WIDTH  SRAM data pins (read path)
sram_data_o  out  SRAM_DATA_WIDTH  SRAM data pins (write path)
sram_data_t_o  out  1  1 = tristate data pins; the top level builds the IOBUF
sram_ce_n_o  out  1  chip enable, active-low
sram_oe_n_o  out  1  output enable, active-low
sram_we_n_o  out  1  write enable, active-low
sram_be_n_o  out  SRAM_DATA_WIDTH/8  byte enables, active-low

Behaviour:
- Reset values (applied immediately, async):
  - state = IDLE; wb_ack_o = 0; wb_dat_o = 0.
  - sram_ce_n_o, sram_oe_n_o and sram_we_n_o = 1; sram_be_n_o = all 1; sram_data_t_o = 1.
  - sram_addr_o = 0; sram_data_o = 0; wait counter = 0.
- Reset mid-access aborts the SRAM cycle at once. No ack is issued.
- SRAM pin outputs are decoded only from the state flops and the registered address/data/sel. There is no combinational path from wb_* inputs to SRAM pins.
- Latched in IDLE when wb_cyc_i & wb_stb_i:
  - addr = wb_adr_i[SRAM_ADDR_WIDTH+1:2]; wb_adr_i[1:0] and the upper bits are ignored, so addresses alias.
  - sel, dat and we.
  - counter = WAIT_CYCLES.
- State machine:
  - IDLE: all SRAM controls inactive; go to READ if !we, else WR_SETUP.
  - READ: ce_n = 0, oe_n = 0, be_n = ~sel, data tristated. Counter decrements each cycle. When counter == 0, capture sram_data_i into wb_dat_o and go to DONE. Duration is WAIT_CYCLES+1 cycles.
  - WR_SETUP (1 cycle): ce_n = 0, we_n = 1, be_n = ~sel, data driven (t = 0). Reload counter = WAIT_CYCLES, go to WRITE.
  - WRITE: as WR_SETUP but we_n = 0, for WAIT_CYCLES+1 cycles, then WR_HOLD.
  - WR_HOLD (1 cycle): we_n = 1, ce_n = 0, data still driven; go to DONE.
  - DONE (1 cycle): SRAM controls inactive, data tristated; go to IDLE.
- Acknowledge:
  - wb_ack_o = (state == DONE) & wb_cyc_i, so it is high for exactly one cycle.
  - wb_dat_o holds the captured word until the next read capture.
- Latency, from the edge that samples the request (cycle 0):
  - Read ack in cycle WAIT_CYCLES+2.
  - Write ack in cycle WAIT_CYCLES+4.
- Boundary conditions:
  - Master drops cyc mid-access: the SRAM cycle runs to completion (no truncated writes), no ack is issued, and the FSM returns to IDLE.
  - sel = 0000: a full cycle runs with be_n = 1111, ack is issued, memory is unchanged.
  - Back-to-back requests: a request is sampled only in IDLE. The minimum gap is one IDLE cycle after DONE.
  - wb_we_i, wb_sel_i and wb_dat_i changing after the request is latched have no effect.
- Data pins are never driven while oe_n = 0: the read path and write path never overlap in one state.

Decomposition:
- Shared package sram_pkg holds:
  - the state enum (IDLE, READ, WR_SETUP, WRITE, WR_HOLD, DONE);
  - SRAM_BYTES = SRAM_DATA_WIDTH/8 and SRAM_BYTE_WIDTH = $clog2(SRAM_BYTES);
  - the wait counter width (4).
- Single module, no sub-module; the wait counter is inline.

Test Plan:
- Word write, WAIT_CYCLES=1, adr 0x8000_0010, dat 0xDEADBEEF, sel 1111 -> sram_addr_o 0x00004, be_n 0000, we_n low exactly 2 cycles inside a 4-cycle driven window, one-cycle ack in cycle 5.
- Word read of adr 0x8000_0010 after that write -> oe_n low 2 cycles, data_t high throughout, wb_dat_o 0xDEADBEEF with ack in cycle 3.
- Byte write adr 0x8000_0012, sel 0100, dat 0x00AB0000, then word read -> be_n 1011 during the write; read returns 0xDEABBEEF from the SRAM model.
- rst_i pulsed while in WRITE -> we_n, ce_n and data_t go to 1 in the same cycle without a clock edge; no ack; the following read completes normally.
- wb_cyc_i dropped during READ -> no ack, FSM returns to IDLE; the next request is acked with correct data.
- WAIT_CYCLES=0 build -> read ack in cycle 2, write ack in cycle 4, we_n low exactly 1 cycle.

Source files
------------

// File: rtl/sram_wb_ctrl_pkg.sv
// Shared state encoding and sizing for the Wishbone-to-asynchronous-SRAM controller.
package sram_pkg;
   typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WRITE, WR_HOLD, DONE} sram_state_e;

   localparam int SRAM_DATA_W     = 32;
   localparam int SRAM_BYTES      = SRAM_DATA_W / 8;
   localparam int SRAM_BYTE_WIDTH = $clog2(SRAM_BYTES);
   localparam int WAIT_CNT_W      = 4;
endpackage

// File: rtl/sram_wb_ctrl_if.sv
// Wishbone B4 classic single-beat bus between the data-memory master and the SRAM controller.
interface sram_wb_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic                    ack;
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH-1:0]   dat_w;
   logic [DATA_WIDTH-1:0]   dat_r;
   logic [DATA_WIDTH/8-1:0] sel;

   modport master (output cyc, stb, we, adr, dat_w, sel, input  ack, dat_r);
   modport slave  (input  cyc, stb, we, adr, dat_w, sel, output ack, dat_r);
endinterface

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave driving one asynchronous 32-bit SRAM bank with fixed, parameterised strobe widths.
// SRAM pins decode only from state and latched request fields, so bus glitches never reach the chip.
module sram_wb_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int SRAM_DATA_WIDTH = 32,
   parameter int WAIT_CYCLES     = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   sram_wb_ctrl_if.slave                wb,
   output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_o,
   input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
   output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
   output logic                         sram_data_t_o,
   output logic                         sram_ce_n_o,
   output logic                         sram_oe_n_o,
   output logic                         sram_we_n_o,
   output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n_o
);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);
   localparam int                    ALO     = SRAM_BYTE_WIDTH;

   sram_state_e                    state_q, state_d;
   logic [WAIT_CNT_W-1:0]          cnt_q, cnt_d;
   logic [SRAM_ADDR_WIDTH-1:0]     addr_q;
   logic [SRAM_DATA_WIDTH-1:0]     dat_q;
   logic [SRAM_DATA_WIDTH/8-1:0]   sel_q;
   logic [DATA_WIDTH-1:0]          rdata_q;
   logic                           latch, capture, be_act;
   logic                           unused_adr;

   // Byte offset and bits above the SRAM span are dropped, so addresses alias.
   assign unused_adr = ^{wb.adr[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+ALO], wb.adr[ALO-1:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            addr_q <= wb.adr[SRAM_ADDR_WIDTH+ALO-1:ALO];
            dat_q  <= wb.dat_w;
            sel_q  <= wb.sel;
         end
         if (capture) rdata_q <= sram_data_i;
      end
   end

   // Direction is consumed by the IDLE branch and lives on in the state encoding.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      latch         = 1'b0;
      capture       = 1'b0;
      sram_ce_n_o   = 1'b1;
      sram_oe_n_o   = 1'b1;
      sram_we_n_o   = 1'b1;
      sram_data_t_o = 1'b1;
      be_act        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wb.cyc && wb.stb) begin
               latch   = 1'b1;
               cnt_d   = WAIT_LD;
               state_d = wb.we ? WR_SETUP : READ;
            end
         end
         READ: begin
            sram_ce_n_o = 1'b0;
            sram_oe_n_o = 1'b0;
            be_act      = 1'b1;
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_SETUP: begin
            sram_ce_n_o   = 1'b0;
            sram_data_t_o = 1'b0;
            be_act        = 1'b1;
            cnt_d         = WAIT_LD;
            state_d       = WRITE;
         end
         WRITE: begin
            sram_ce_n_o   = 1'b0;
            sram_we_n_o   = 1'b0;
            sram_data_t_o = 1'b0;
            be_act        = 1'b1;
            if (cnt_q == '0) state_d = WR_HOLD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         WR_HOLD: begin
            sram_ce_n_o   = 1'b0;
            sram_data_t_o = 1'b0;
            be_act        = 1'b1;
            state_d       = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign sram_addr_o = addr_q;
   assign sram_data_o = dat_q;
   assign sram_be_n_o = be_act ? ~sel_q : '1;

   // A master that abandoned the cycle gets no ack; the SRAM access still completes.
   assign wb.ack   = (state_q == DONE) & wb.cyc;
   assign wb.dat_r = rdata_q;
endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Scoreboard bench for sram_wb_ctrl: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=0,
// each with its own byte-lane SRAM model and pin-activity counters checked at every ack.
module tb_sram_wb_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, cyc, stb, we, ack, t, ce, oe, wen;
   logic [1:0][31:0] adr, dat, rdat, sdo, sdi;
   logic [1:0][3:0]  sel, be;
   logic [1:0][19:0] sa;
   logic [31:0]      mem [2][256];

   sram_wb_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb0 ();
   sram_wb_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb1 ();

   assign wb0.cyc = cyc[0]; assign wb0.stb = stb[0]; assign wb0.we = we[0];
   assign wb0.adr = adr[0]; assign wb0.dat_w = dat[0]; assign wb0.sel = sel[0];
   assign ack[0] = wb0.ack; assign rdat[0] = wb0.dat_r;
   assign wb1.cyc = cyc[1]; assign wb1.stb = stb[1]; assign wb1.we = we[1];
   assign wb1.adr = adr[1]; assign wb1.dat_w = dat[1]; assign wb1.sel = sel[1];
   assign ack[1] = wb1.ack; assign rdat[1] = wb1.dat_r;
   assign sdi[0] = mem[0][sa[0][7:0]];
   assign sdi[1] = mem[1][sa[1][7:0]];

   sram_wb_ctrl #(.WAIT_CYCLES(1)) u0 (
      .clk_i(clk), .rst_i(rst[0]), .wb(wb0.slave),
      .sram_addr_o(sa[0]), .sram_data_i(sdi[0]), .sram_data_o(sdo[0]), .sram_data_t_o(t[0]),
      .sram_ce_n_o(ce[0]), .sram_oe_n_o(oe[0]), .sram_we_n_o(wen[0]), .sram_be_n_o(be[0]));

   sram_wb_ctrl #(.WAIT_CYCLES(0)) u1 (
      .clk_i(clk), .rst_i(rst[1]), .wb(wb1.slave),
      .sram_addr_o(sa[1]), .sram_data_i(sdi[1]), .sram_data_o(sdo[1]), .sram_data_t_o(t[1]),
      .sram_ce_n_o(ce[1]), .sram_oe_n_o(oe[1]), .sram_we_n_o(wen[1]), .sram_be_n_o(be[1]));

   typedef struct {
      int          d;
      bit          rd;
      logic [31:0] rdata;
      int          start;
      int          lat;
      logic [19:0] addr;
      logic [3:0]  be_n;
      int          we_low;
      int          drv;
      int          oe_low;
      string       nm;
   } exp_t;

   exp_t q[$];

   // Hand-derived per-instance figures: index 0 is WAIT_CYCLES=1, index 1 is WAIT_CYCLES=0.
   int LAT_RD [2] = '{3, 2};
   int LAT_WR [2] = '{5, 4};
   int OE_LOW [2] = '{2, 1};
   int WE_LOW [2] = '{2, 1};
   int DRV    [2] = '{4, 3};

   int cc = 0;
   int n_cmp = 0, n_bad = 0;
   int ack_cnt [2] = '{0, 0};
   int abort_seq [2] = '{0, 0};
   int abort_seen [2] = '{0, 0};
   int st_ce [2], st_we [2], st_drv [2], st_oe [2], st_ovl [2];
   logic [19:0] st_addr [2];
   logic [3:0]  st_be [2];
   bit          st_bad [2];
   bit          held = 1'b0;

   initial forever begin
      @(posedge clk);
      cc++;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   // Monitor: SRAM model writes, pin-activity counts, and scoreboard pop on every ack.
   initial begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) mem[d][i] = '0;
         st_ce[d] = 0; st_we[d] = 0; st_drv[d] = 0; st_oe[d] = 0; st_ovl[d] = 0;
         st_addr[d] = '0; st_be[d] = '1; st_bad[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (abort_seen[d] != abort_seq[d]) begin
               abort_seen[d] = abort_seq[d];
               st_ce[d] = 0; st_we[d] = 0; st_drv[d] = 0; st_oe[d] = 0; st_ovl[d] = 0; st_bad[d] = 1'b0;
            end
            if (!ce[d]) begin
               st_ce[d]++;
               if (st_ce[d] == 1) begin
                  st_addr[d] = sa[d];
                  st_be[d]   = be[d];
               end else if (sa[d] !== st_addr[d] || be[d] !== st_be[d]) begin
                  st_bad[d] = 1'b1;
               end
               if (!wen[d]) begin
                  st_we[d]++;
                  for (int b = 0; b < 4; b++)
                     if (!be[d][b]) mem[d][sa[d][7:0]][8*b +: 8] = sdo[d][8*b +: 8];
               end
            end
            if (!t[d]) st_drv[d]++;
            if (!oe[d]) st_oe[d]++;
            if (!oe[d] && !t[d]) st_ovl[d]++;
            if (ack[d]) begin
               ack_cnt[d]++;
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_ack dut%0d: got ack, want none", d);
               end else begin
                  e = q.pop_front();
                  chk({e.nm, "_dut"}, d, e.d);
                  chk({e.nm, "_lat"}, cc - e.start, e.lat);
                  if (e.rd) chk({e.nm, "_rdata"}, rdat[d], e.rdata);
                  chk({e.nm, "_addr"}, 32'(st_addr[d]), 32'(e.addr));
                  chk({e.nm, "_be_n"}, 32'(st_be[d]), 32'(e.be_n));
                  chk({e.nm, "_we_low"}, st_we[d], e.we_low);
                  chk({e.nm, "_drv"}, st_drv[d], e.drv);
                  chk({e.nm, "_oe_low"}, st_oe[d], e.oe_low);
                  chk({e.nm, "_overlap"}, st_ovl[d], 0);
                  chk({e.nm, "_stable"}, 32'(st_bad[d]), 0);
               end
               st_ce[d] = 0; st_we[d] = 0; st_drv[d] = 0; st_oe[d] = 0; st_ovl[d] = 0; st_bad[d] = 1'b0;
            end
         end
      end
   end

   // Called at negedge+1 in an IDLE cycle, or in the DONE cycle of a transfer that kept cyc high.
   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [31:0] exp_rd, input logic [19:0] exp_addr,
                       input logic [3:0] exp_be, input bit hold, input string nm);
      exp_t e;
      int   st;
      bit   got;
      st       = held ? cc + 1 : cc;
      e.d      = d;
      e.rd     = !w;
      e.rdata  = exp_rd;
      e.start  = st;
      e.lat    = w ? LAT_WR[d] : LAT_RD[d];
      e.addr   = exp_addr;
      e.be_n   = exp_be;
      e.we_low = w ? WE_LOW[d] : 0;
      e.drv    = w ? DRV[d] : 0;
      e.oe_low = w ? 0 : OE_LOW[d];
      e.nm     = nm;
      q.push_back(e);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = wd; sel[d] = s;
      while (cc < st + 1) @(negedge clk);
      #1;
      we[d] = ~w; sel[d] = ~s; dat[d] = ~wd; adr[d] = ~a;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = ack[d];
      end
      chk({nm, "_acked"}, 32'(got), 1);
      #1;
      held = hold;
      if (!hold) begin
         cyc[d] = 1'b0; stb[d] = 1'b0;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic drop_req(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input string nm);
      int st, base;
      st   = cc;
      base = ack_cnt[d];
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = wd; sel[d] = s;
      while (cc < st + 1) @(negedge clk);
      #1;
      cyc[d] = 1'b0; stb[d] = 1'b0;
      repeat (8) @(negedge clk);
      chk({nm, "_no_ack"}, ack_cnt[d], base);
      abort_seq[d]++;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int base;
      bit got;
      rst = 2'b11; cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0;
      #2;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ctl%0d", d), 32'({ce[d], oe[d], wen[d], t[d]}), 32'hF);
         chk($sformatf("rst_be%0d", d), 32'(be[d]), 32'hF);
         chk($sformatf("rst_addr%0d", d), 32'(sa[d]), 0);
         chk($sformatf("rst_wdata%0d", d), sdo[d], 0);
         chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 0);
         chk($sformatf("rst_rdata%0d", d), rdat[d], 0);
      end
      repeat (3) @(negedge clk);
      #1 rst = 2'b00;
      @(negedge clk);
      #1;

      xfer(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         20'h00004, 4'h0, 0, "wr_word");
      xfer(0, 0, 32'h8000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 20'h00004, 4'h0, 0, "rd_word");
      xfer(0, 1, 32'h8000_0012, 32'h00AB_0000, 4'h4, 32'h0,         20'h00004, 4'hB, 0, "wr_byte");
      xfer(0, 0, 32'h8000_0010, 32'h0,         4'hF, 32'hDEAB_BEEF, 20'h00004, 4'h0, 0, "rd_byte");
      xfer(0, 1, 32'h8000_0010, 32'h1111_1111, 4'h0, 32'h0,         20'h00004, 4'hF, 0, "wr_sel0");
      xfer(0, 0, 32'hC040_0013, 32'h0,         4'hF, 32'hDEAB_BEEF, 20'h00004, 4'h0, 0, "rd_alias");

      drop_req(0, 0, 32'h8000_0020, 32'h0, 4'hF, "drop_rd");
      xfer(0, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 32'h0,         20'h00008, 4'h0, 1, "b2b_wr");
      xfer(0, 0, 32'h0000_0020, 32'h0,         4'hF, 32'hCAFE_F00D, 20'h00008, 4'h0, 0, "b2b_rd");

      // Reset in the middle of the write strobe.
      base = ack_cnt[0];
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0000_0030;
      dat[0] = 32'h1234_5678; sel[0] = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = !wen[0];
      end
      chk("rst_we_reached", 32'(got), 1);
      #1 rst[0] = 1'b1;
      #1;
      chk("rst_async_ctl", 32'({ce[0], wen[0], t[0], oe[0]}), 32'hF);
      chk("rst_async_be", 32'(be[0]), 32'hF);
      @(negedge clk);
      #1;
      rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_no_ack", ack_cnt[0], base);
      abort_seq[0]++;
      @(negedge clk);
      #1;
      xfer(0, 0, 32'h0000_0020, 32'h0, 4'hF, 32'hCAFE_F00D, 20'h00008, 4'h0, 0, "post_rst_rd");

      xfer(1, 1, 32'h0000_0040, 32'h55AA_55AA, 4'hF, 32'h0,         20'h00010, 4'h0, 0, "w0_wr");
      xfer(1, 0, 32'h0000_0040, 32'h0,         4'hF, 32'h55AA_55AA, 20'h00010, 4'h0, 0, "w0_rd");
      drop_req(1, 1, 32'h0000_0044, 32'h0BAD_CAFE, 4'hF, "w0_drop_wr");
      xfer(1, 0, 32'h0000_0044, 32'h0,         4'hF, 32'h0BAD_CAFE, 20'h00011, 4'h0, 0, "w0_rd_after_drop");

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
